// File: rtl/wb_commit_unit_pkg.sv
// wb_commit_unit_pkg: shared widths and FSM state encoding for the write-back commit unit.
package wb_commit_unit_pkg;
  localparam int ADDRESS_LEN = 32;
  localparam int REG_IDX_W = 4;
  typedef enum logic {IDLE = 1'b0, WAIT_LOAD = 1'b1} state_t;
endpackage

// File: rtl/wb_commit_unit_if.sv
// wb_commit_unit_if: MEM-stage input, memory response and register-file write-back bundle.
// master: MEM stage / memory side (drives in_*, mem_rsp_*); slave: wb_commit_unit.
// With WB_FORWARD_EN defined, also carries fwd_valid/fwd_dst/fwd_value.
interface wb_commit_unit_if import wb_commit_unit_pkg::*; #(
  parameter int DATA_W = ADDRESS_LEN,
  parameter int REG_W = REG_IDX_W
) ();
  logic in_valid;
  logic in_ready;
  logic in_wb_en;
  logic in_mem_r_en;
  logic [REG_W-1:0] in_dst;
  logic [DATA_W-1:0] in_alu_result;
  logic mem_rsp_valid;
  logic [DATA_W-1:0] mem_rsp_data;
  logic regfile_wb_en;
  logic [REG_W-1:0] regFile_dst;
  logic [DATA_W-1:0] wb_value;
  logic pending_valid;
  logic [REG_W-1:0] pending_dst;
  logic load_timeout;
  logic stray_rsp;
`ifdef WB_FORWARD_EN
  logic fwd_valid;
  logic [REG_W-1:0] fwd_dst;
  logic [DATA_W-1:0] fwd_value;
  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_dst, in_alu_result, mem_rsp_valid, mem_rsp_data,
    input in_ready, regfile_wb_en, regFile_dst, wb_value, pending_valid, pending_dst,
    load_timeout, stray_rsp, fwd_valid, fwd_dst, fwd_value
  );
  modport slave (
    input in_valid, in_wb_en, in_mem_r_en, in_dst, in_alu_result, mem_rsp_valid, mem_rsp_data,
    output in_ready, regfile_wb_en, regFile_dst, wb_value, pending_valid, pending_dst,
    load_timeout, stray_rsp, fwd_valid, fwd_dst, fwd_value
  );
`else
  modport master (
    output in_valid, in_wb_en, in_mem_r_en, in_dst, in_alu_result, mem_rsp_valid, mem_rsp_data,
    input in_ready, regfile_wb_en, regFile_dst, wb_value, pending_valid, pending_dst,
    load_timeout, stray_rsp
  );
  modport slave (
    input in_valid, in_wb_en, in_mem_r_en, in_dst, in_alu_result, mem_rsp_valid, mem_rsp_data,
    output in_ready, regfile_wb_en, regFile_dst, wb_value, pending_valid, pending_dst,
    load_timeout, stray_rsp
  );
`endif
endinterface

// File: rtl/wb_commit_unit_load_timer.sv
// wb_load_timer: saturating load-wait counter; clr zeroes it, en advances it, expire flags TIMEOUT-1.
// Ports: clk, rst (async high), clr, en, expire.
module wb_load_timer #(
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] cnt;
  assign expire = cnt == LAST;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expire) cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/wb_commit_unit.sv
// wb_commit_unit: commits one ALU or load result per cycle to the register file, waiting on slow loads.
// Ports: clk, rst (async high), bus (wb_commit_unit_if.slave).
// Optional WB_FORWARD_EN: drives bus.fwd_* with the write that lands next cycle.
module wb_commit_unit import wb_commit_unit_pkg::*; #(
  parameter int DATA_W = ADDRESS_LEN,
  parameter int REG_W = REG_IDX_W,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  wb_commit_unit_if.slave bus
);
  state_t state_q, state_d;
  logic ld_wb_q;
  logic [REG_W-1:0] ld_dst_q;
  logic en_q, en_d;
  logic [REG_W-1:0] dst_q, dst_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic to_q, to_d, stray_q, stray_d;
  logic idle, acc, clr, expire;
  assign idle = state_q == IDLE;
  assign acc = bus.in_valid && idle;
  wb_load_timer #(.TIMEOUT(TIMEOUT)) u_timer (.clk, .rst, .clr, .en(!idle), .expire);
  always_comb begin
    state_d = state_q;
    en_d = 1'b0;
    dst_d = dst_q;
    val_d = val_q;
    to_d = to_q;
    clr = 1'b0;
    // a response only counts as stray if no load is being accepted alongside it
    stray_d = stray_q | (idle && bus.mem_rsp_valid && !(acc && bus.in_mem_r_en));
    if (idle) begin
      if (acc && (!bus.in_mem_r_en || bus.mem_rsp_valid)) begin
        en_d = bus.in_wb_en;
        dst_d = bus.in_wb_en ? bus.in_dst : dst_q;
        val_d = !bus.in_wb_en ? val_q : bus.in_mem_r_en ? bus.mem_rsp_data : bus.in_alu_result;
      end else if (acc) begin
        state_d = WAIT_LOAD;
        clr = 1'b1;
      end
    end else if (bus.mem_rsp_valid) begin
      en_d = ld_wb_q;
      dst_d = ld_wb_q ? ld_dst_q : dst_q;
      val_d = ld_wb_q ? bus.mem_rsp_data : val_q;
      state_d = IDLE;
    end else if (expire) begin
      to_d = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ld_wb_q <= 1'b0;
      ld_dst_q <= '0;
      en_q <= 1'b0;
      dst_q <= '0;
      val_q <= '0;
      to_q <= 1'b0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q <= en_d;
      dst_q <= dst_d;
      val_q <= val_d;
      to_q <= to_d;
      stray_q <= stray_d;
      if (clr) begin
        ld_wb_q <= bus.in_wb_en;
        ld_dst_q <= bus.in_dst;
      end
    end
  end
  assign bus.in_ready = idle;
  assign bus.regfile_wb_en = en_q;
  assign bus.regFile_dst = dst_q;
  assign bus.wb_value = val_q;
  assign bus.pending_valid = !idle;
  assign bus.pending_dst = idle ? '0 : ld_dst_q;
  assign bus.load_timeout = to_q;
  assign bus.stray_rsp = stray_q;
`ifdef WB_FORWARD_EN
  assign bus.fwd_valid = en_d;
  assign bus.fwd_dst = dst_d;
  assign bus.fwd_value = val_d;
`endif
endmodule

// File: tb/tb_wb_commit_unit.sv
// tb_wb_commit_unit: directed checks of wb_commit_unit (default TIMEOUT and TIMEOUT=8 instances).
module tb_wb_commit_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int e = 0;
  always #5 clk = ~clk;
  wb_commit_unit_if #(.DATA_W(32), .REG_W(4)) a ();
  wb_commit_unit_if #(.DATA_W(32), .REG_W(4)) b ();
  wb_commit_unit #(.DATA_W(32), .REG_W(4), .TIMEOUT(64)) u_dut (.clk(clk), .rst(rst), .bus(a.slave));
  wb_commit_unit #(.DATA_W(32), .REG_W(4), .TIMEOUT(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b.slave));
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      e++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive_a(input logic v, input logic we, input logic ld, input logic [3:0] d,
                         input logic [31:0] alu, input logic rv, input logic [31:0] rd);
    a.in_valid = v; a.in_wb_en = we; a.in_mem_r_en = ld; a.in_dst = d;
    a.in_alu_result = alu; a.mem_rsp_valid = rv; a.mem_rsp_data = rd;
  endtask
  task automatic drive_b(input logic v, input logic we, input logic ld, input logic [3:0] d,
                         input logic rv, input logic [31:0] rd);
    b.in_valid = v; b.in_wb_en = we; b.in_mem_r_en = ld; b.in_dst = d;
    b.in_alu_result = 32'h0; b.mem_rsp_valid = rv; b.mem_rsp_data = rd;
  endtask
  initial begin
    drive_a(0, 0, 0, 0, 0, 0, 0);
    drive_b(0, 0, 0, 0, 0, 0);
    cyc(); cyc();
    chk("rst_wb_en", a.regfile_wb_en, 0);
    chk("rst_dst", a.regFile_dst, 0);
    chk("rst_value", a.wb_value, 0);
    chk("rst_pending", a.pending_valid, 0);
    chk("rst_pdst", a.pending_dst, 0);
    chk("rst_timeout", a.load_timeout, 0);
    chk("rst_stray", a.stray_rsp, 0);
    chk("rst_ready", a.in_ready, 1);
    rst = 1'b0;
    cyc();
    drive_a(1, 1, 0, 3, 32'h12345678, 0, 0);
    chk("alu_ready", a.in_ready, 1);
    cyc();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    chk("alu_wb_en", a.regfile_wb_en, 1);
    chk("alu_dst", a.regFile_dst, 3);
    chk("alu_value", a.wb_value, 32'h12345678);
    cyc();
    chk("alu_pulse_end", a.regfile_wb_en, 0);
    chk("alu_dst_hold", a.regFile_dst, 3);
    drive_a(1, 1, 1, 5, 0, 1, 32'hCAFEBABE);
    cyc();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    chk("ld0_wb_en", a.regfile_wb_en, 1);
    chk("ld0_dst", a.regFile_dst, 5);
    chk("ld0_value", a.wb_value, 32'hCAFEBABE);
    chk("ld0_ready", a.in_ready, 1);
    chk("ld0_pending", a.pending_valid, 0);
    chk("ld0_stray", a.stray_rsp, 0);
    cyc();
    chk("ld0_pulse_end", a.regfile_wb_en, 0);
    drive_a(1, 1, 1, 7, 0, 0, 0);
    cyc();
    drive_a(1, 1, 0, 9, 32'h00000ABC, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      chk("ldw_ready", a.in_ready, 0);
      chk("ldw_pending", a.pending_valid, 1);
      chk("ldw_pdst", a.pending_dst, 7);
      chk("ldw_no_wb", a.regfile_wb_en, 0);
      if (i == 10) begin
        a.mem_rsp_valid = 1'b1;
        a.mem_rsp_data = 32'hDEAD0001;
      end
      cyc();
    end
    a.mem_rsp_valid = 1'b0;
    chk("ldw_wb_en", a.regfile_wb_en, 1);
    chk("ldw_dst", a.regFile_dst, 7);
    chk("ldw_value", a.wb_value, 32'hDEAD0001);
    chk("ldw_ready_back", a.in_ready, 1);
    chk("ldw_pending_clr", a.pending_valid, 0);
    cyc();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    chk("held_wb_en", a.regfile_wb_en, 1);
    chk("held_dst", a.regFile_dst, 9);
    chk("held_value", a.wb_value, 32'h00000ABC);
    drive_a(1, 0, 1, 4, 0, 0, 0);
    cyc();
    drive_a(0, 0, 0, 0, 0, 1, 32'h11111111);
    chk("nowb_ready", a.in_ready, 0);
    chk("nowb_pending", a.pending_valid, 1);
    cyc();
    a.mem_rsp_valid = 1'b0;
    chk("nowb_wb_en", a.regfile_wb_en, 0);
    chk("nowb_dst_hold", a.regFile_dst, 9);
    chk("nowb_value_hold", a.wb_value, 32'h00000ABC);
    chk("nowb_idle", a.in_ready, 1);
    chk("nowb_stray", a.stray_rsp, 0);
    drive_a(1, 1, 0, 15, 32'hFFFF0000, 0, 0);
    cyc();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    chk("r15_wb_en", a.regfile_wb_en, 1);
    chk("r15_dst", a.regFile_dst, 15);
    chk("r15_value", a.wb_value, 32'hFFFF0000);
    a.mem_rsp_valid = 1'b1;
    cyc();
    a.mem_rsp_valid = 1'b0;
    chk("stray_set", a.stray_rsp, 1);
    chk("stray_no_wb", a.regfile_wb_en, 0);
    cyc();
    chk("stray_sticky", a.stray_rsp, 1);
    drive_b(1, 1, 1, 2, 0, 0);
    cyc();
    drive_b(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      chk("to_pending", b.pending_valid, 1);
      chk("to_not_yet", b.load_timeout, 0);
      cyc();
    end
    chk("to_set", b.load_timeout, 1);
    chk("to_pending_clr", b.pending_valid, 0);
    chk("to_no_wb", b.regfile_wb_en, 0);
    chk("to_idle", b.in_ready, 1);
    cyc();
    chk("to_sticky", b.load_timeout, 1);
    chk("to_no_wb_late", b.regfile_wb_en, 0);
    drive_b(1, 1, 1, 1, 0, 0);
    cyc();
    drive_b(0, 0, 0, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        b.mem_rsp_valid = 1'b1;
        b.mem_rsp_data = 32'h00000077;
      end
      cyc();
    end
    b.mem_rsp_valid = 1'b0;
    chk("edge_wb_en", b.regfile_wb_en, 1);
    chk("edge_dst", b.regFile_dst, 1);
    chk("edge_value", b.wb_value, 32'h00000077);
    chk("edge_stray", b.stray_rsp, 0);
    drive_a(1, 1, 1, 6, 0, 0, 0);
    cyc();
    drive_a(0, 0, 0, 0, 0, 0, 0);
    cyc();
    chk("rw_pending", a.pending_valid, 1);
    rst = 1'b1;
    #1;
    chk("rw_wb_en", a.regfile_wb_en, 0);
    chk("rw_dst", a.regFile_dst, 0);
    chk("rw_value", a.wb_value, 0);
    chk("rw_pending_clr", a.pending_valid, 0);
    chk("rw_pdst", a.pending_dst, 0);
    chk("rw_stray_clr", a.stray_rsp, 0);
    chk("rw_ready", a.in_ready, 1);
    chk("rw_b_timeout_clr", b.load_timeout, 0);
    #1;
    rst = 1'b0;
    a.mem_rsp_valid = 1'b1;
    a.mem_rsp_data = 32'h55555555;
    cyc();
    a.mem_rsp_valid = 1'b0;
    chk("late_stray", a.stray_rsp, 1);
    chk("late_no_wb", a.regfile_wb_en, 0);
    chk("late_value", a.wb_value, 0);
    cyc();
    chk("late_no_wb2", a.regfile_wb_en, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n, e);
    $finish;
  end
endmodule
